// File: rtl/sv32_dtlb_translate.sv
// sv32_dtlb_translate: SV32 data-side VA->PA translation with a fully associative, ASID-tagged TLB
//
// Sits between the LSU address path and the shared page table walker; hits translate without a walk.
// Supports 4 KiB pages, 4 MiB megapages, satp bare mode, MPRV/MPP, SUM, MXR and sfence.vma flush.
//
// Parameters: TLB_ENTRIES (power of two, 1..16), ASID_BITS (satp[30:22] tag width, 0 = no tagging)
// Build option: SV32_AD_CHECK_EN adds A=0 / store-with-D=0 faults (software-managed A/D bits).
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   address, is_write    virtual address and access type (1 = store/AMO)
//   privilege_mode       current privilege
//   satp, mstatus        CSRs (satp MODE/ASID; mstatus MPRV, MPP, SUM, MXR)
//   valid / ready        request held until the one-cycle ready pulse
//   physical_address     34-bit result, all ones on fault
//   page_fault, tlb_hit  result qualifiers, pulse with ready
//   walk_valid/_ready    PTW handshake; walk_pte/walk_level valid with walk_ready
//   tlb_flush            one-cycle pulse invalidating every entry
module sv32_dtlb_translate #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_BITS   = 9
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic        is_write,
    input  logic [1:0]  privilege_mode,
    input  logic [31:0] satp,
    input  logic [31:0] mstatus,
    input  logic        valid,
    output logic        ready,
    output logic [33:0] physical_address,
    output logic        page_fault,
    output logic        tlb_hit,
    output logic        walk_valid,
    input  logic        walk_ready,
    input  logic [31:0] walk_pte,
    input  logic        walk_level,
    input  logic        tlb_flush
);
    localparam int IW = TLB_ENTRIES > 1 ? $clog2(TLB_ENTRIES) : 1;
    localparam int AW = ASID_BITS > 0 ? ASID_BITS : 1;
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;
    localparam logic [33:0] FAULT_PA = 34'h3_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, WALK, CHECK} state_t;
    state_t state_q, state_d;

    logic        ready_q, ready_d, fault_q, fault_d, hit_q, hit_d;
    logic [33:0] pa_q, pa_d;
    logic [31:0] req_va_q, req_va_d, wpte_q, wpte_d;
    logic        req_wr_q, req_wr_d, wmega_q, wmega_d;
    logic        flushed_q, flushed_d, dropped_q, dropped_d;

    logic [TLB_ENTRIES-1:0] ent_v_q, ent_v_d, ent_mega_q, match;
    logic [19:0]   ent_vpn_q  [TLB_ENTRIES];
    logic [AW-1:0] ent_asid_q [TLB_ENTRIES];
    logic [31:0]   ent_pte_q  [TLB_ENTRIES];
    logic [IW-1:0] rr_q, rr_d, hit_idx, victim;
    logic          lookup_hit, has_free, fill, hit_fault, walk_fault;

    logic [1:0]    eff_priv;
    logic          sum, mxr, bare, unused_ok;
    logic [AW-1:0] asid;

    assign eff_priv  = mstatus[17] ? mstatus[12:11] : privilege_mode;
    assign sum       = mstatus[18];
    assign mxr       = mstatus[19];
    assign bare      = eff_priv == PRIV_M || !satp[31];
    assign asid      = ASID_BITS > 0 ? satp[22 +: AW] : '0;
    assign unused_ok = ^{satp, mstatus};

    function automatic logic pte_fault(input logic [31:0] pte, input logic mega, input logic wr,
                                       input logic [1:0] priv, input logic s_um, input logic m_xr);
        logic rd;
        rd = pte[1] | (m_xr & pte[3]);
        pte_fault = !pte[0] || (pte[2] && !pte[1]) || !(pte[1] || pte[3])
                 || (mega && pte[19:10] != 10'd0)
                 || (priv == PRIV_S && pte[4] && !s_um)
                 || (priv == PRIV_U && !pte[4])
                 || (wr ? !pte[2] : !rd)
`ifdef SV32_AD_CHECK_EN
                 || !pte[6] || (wr && !pte[7])
`endif
                 ;
    endfunction

    function automatic logic [33:0] pa_of(input logic [31:0] pte, input logic mega, input logic [31:0] va);
        pa_of = mega ? {pte[31:20], va[21:0]} : {pte[31:10], va[11:0]};
    endfunction

    // Megapage entries compare VPN1 only; global entries ignore the ASID.
    always_comb begin
        match      = '0;
        lookup_hit = 1'b0;
        hit_idx    = '0;
        has_free   = 1'b0;
        victim     = rr_q;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            match[i] = ent_v_q[i] && ent_vpn_q[i][19:10] == address[31:22]
                    && (ent_mega_q[i] || ent_vpn_q[i][9:0] == address[21:12])
                    && (ASID_BITS == 0 || ent_pte_q[i][5] || ent_asid_q[i] == asid);
            if (match[i]) begin
                lookup_hit = 1'b1;
                hit_idx    = IW'(i);
            end
            if (!ent_v_q[i]) begin
                has_free = 1'b1;
                victim   = IW'(i);
            end
        end
    end

    assign hit_fault  = pte_fault(ent_pte_q[hit_idx], ent_mega_q[hit_idx], is_write, eff_priv, sum, mxr);
    assign walk_fault = pte_fault(wpte_q, wmega_q, req_wr_q, eff_priv, sum, mxr);

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        hit_d     = 1'b0;
        pa_d      = pa_q;
        req_va_d  = req_va_q;
        req_wr_d  = req_wr_q;
        wpte_d    = wpte_q;
        wmega_d   = wmega_q;
        flushed_d = flushed_q | tlb_flush;
        dropped_d = dropped_q | !valid;
        fill      = 1'b0;
        case (state_q)
            IDLE: if (valid && !ready_q) begin
                if (bare) begin
                    ready_d = 1'b1;
                    pa_d    = {2'b00, address};
                end else if (lookup_hit) begin
                    ready_d = 1'b1;
                    hit_d   = 1'b1;
                    fault_d = hit_fault;
                    pa_d    = hit_fault ? FAULT_PA : pa_of(ent_pte_q[hit_idx], ent_mega_q[hit_idx], address);
                end else begin
                    state_d   = WALK;
                    req_va_d  = address;
                    req_wr_d  = is_write;
                    flushed_d = 1'b0;
                    dropped_d = 1'b0;
                end
            end
            WALK: if (walk_ready) begin
                state_d = CHECK;
                wpte_d  = walk_pte;
                wmega_d = walk_level;
            end
            CHECK: begin
                state_d = IDLE;
                ready_d = valid && !dropped_q;
                fault_d = ready_d && walk_fault;
                pa_d    = !ready_d ? pa_q : walk_fault ? FAULT_PA : pa_of(wpte_q, wmega_q, req_va_q);
                // A flush seen at any point of the walk forbids caching its result.
                fill    = !walk_fault && !flushed_q && !tlb_flush;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ent_v_d = tlb_flush ? '0 : ent_v_q | (fill ? TLB_ENTRIES'(1) << victim : '0);
    assign rr_d    = fill && !has_free ? (rr_q == IW'(TLB_ENTRIES - 1) ? '0 : rr_q + 1'b1) : rr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            hit_q     <= 1'b0;
            pa_q      <= '0;
            req_va_q  <= '0;
            req_wr_q  <= 1'b0;
            wpte_q    <= '0;
            wmega_q   <= 1'b0;
            flushed_q <= 1'b0;
            dropped_q <= 1'b0;
            ent_v_q   <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            hit_q     <= hit_d;
            pa_q      <= pa_d;
            req_va_q  <= req_va_d;
            req_wr_q  <= req_wr_d;
            wpte_q    <= wpte_d;
            wmega_q   <= wmega_d;
            flushed_q <= flushed_d;
            dropped_q <= dropped_d;
            ent_v_q   <= ent_v_d;
            rr_q      <= rr_d;
        end
    end

    // Entry payload is qualified by ent_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            ent_vpn_q[victim]  <= req_va_q[31:12];
            ent_asid_q[victim] <= asid;
            ent_pte_q[victim]  <= wpte_q;
            ent_mega_q[victim] <= wmega_q;
        end
    end

    assign ready            = ready_q;
    assign physical_address = pa_q;
    assign page_fault       = fault_q;
    assign tlb_hit          = hit_q;
    assign walk_valid       = state_q == WALK;
endmodule

// File: tb/tb_sv32_dtlb_translate.sv
// tb_sv32_dtlb_translate: randomized and directed checks of sv32_dtlb_translate against a behavioural TLB model
module tb_sv32_dtlb_translate;
    localparam int N = 4;
    localparam logic [31:0] S1 = 32'h8040_0000;
    localparam logic [31:0] S2 = 32'h8080_0000;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] address, satp, mstatus, walk_pte;
    logic [1:0]  privilege_mode;
    logic        is_write, valid, walk_ready, walk_level, tlb_flush;
    logic        ready, page_fault, tlb_hit, walk_valid;
    logic [33:0] physical_address;

    always #5 clk = ~clk;

    sv32_dtlb_translate #(.TLB_ENTRIES(N), .ASID_BITS(9)) dut (
        .clk(clk), .resetn(resetn), .address(address), .is_write(is_write),
        .privilege_mode(privilege_mode), .satp(satp), .mstatus(mstatus), .valid(valid),
        .ready(ready), .physical_address(physical_address), .page_fault(page_fault),
        .tlb_hit(tlb_hit), .walk_valid(walk_valid), .walk_ready(walk_ready),
        .walk_pte(walk_pte), .walk_level(walk_level), .tlb_flush(tlb_flush)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural TLB: a list of cached translations with lowest-free / round-robin replacement.
    bit          m_v [N];
    logic [19:0] m_vpn [N];
    logic [8:0]  m_asid [N];
    logic [31:0] m_pte [N];
    bit          m_mega [N];
    int          m_rr;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_rr = 0;
    endfunction

    function automatic int m_lookup(logic [31:0] va, logic [8:0] asid);
        for (int i = 0; i < N; i++)
            if (m_v[i] && va[31:22] == m_vpn[i][19:10] && (m_mega[i] || va[21:12] == m_vpn[i][9:0])
                && (m_pte[i][5] || m_asid[i] == asid)) return i;
        return -1;
    endfunction

    function automatic void m_fill(logic [31:0] va, logic [8:0] asid, logic [31:0] pte, bit mega);
        int v = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % N;
        end
        m_v[v] = 1; m_vpn[v] = va[31:12]; m_asid[v] = asid; m_pte[v] = pte; m_mega[v] = mega;
    endfunction

    function automatic bit m_fault(logic [31:0] p, bit mega, bit wr, logic [1:0] pr, bit sum, bit mxr);
        bit rd = p[1] || (mxr && p[3]);
        if (!p[0] || (p[2] && !p[1])) return 1;
        if (!p[1] && !p[3]) return 1;
        if (mega && p[19:10] != 0) return 1;
        if (pr == 2'd1 && p[4] && !sum) return 1;
        if (pr == 2'd0 && !p[4]) return 1;
        if (wr ? !p[2] : !rd) return 1;
`ifdef SV32_AD_CHECK_EN
        if (!p[6] || (wr && !p[7])) return 1;
`endif
        return 0;
    endfunction

    function automatic logic [33:0] m_pa(logic [31:0] p, bit mega, logic [31:0] va);
        return mega ? {p[31:20], va[21:0]} : {p[31:10], va[11:0]};
    endfunction

    bit          exp_active = 0, exp_miss = 0, exp_fault = 0, exp_hit = 0;
    logic [33:0] exp_pa = '0;

    always @(negedge clk) if (resetn) begin
        if (ready) begin
            check("ready_expected", 34'(exp_active), 34'd1);
            if (exp_active) begin
                check("pa", physical_address, exp_pa);
                check("page_fault", 34'(page_fault), 34'(exp_fault));
                check("tlb_hit", 34'(tlb_hit), 34'(exp_hit));
            end
        end else begin
            check("idle_page_fault", 34'(page_fault), 34'd0);
            check("idle_tlb_hit", 34'(tlb_hit), 34'd0);
        end
        if (walk_valid) check("walk_expected", 34'(exp_miss), 34'd1);
    end

    logic [33:0] last_pa;
    bit          last_fault, last_hit;
    int          last_lat, last_walks;

    task automatic req(input logic [31:0] va, input bit wr, input logic [1:0] pr, input logic [31:0] ms,
                       input logic [31:0] sp, input logic [31:0] pte, input bit lvl, input int dly, input bit fl);
        logic [1:0] ep = ms[17] ? ms[12:11] : pr;
        int idx = -1, cyc = 0, walks = 0;
        bit miss = 0, flt = 0;
        logic [33:0] pa;
        if (ep == 2'd3 || !sp[31]) pa = {2'b00, va};
        else begin
            idx = m_lookup(va, sp[30:22]);
            if (idx >= 0) begin
                flt = m_fault(m_pte[idx], m_mega[idx], wr, ep, ms[18], ms[19]);
                pa  = m_pa(m_pte[idx], m_mega[idx], va);
            end else begin
                miss = 1;
                flt  = m_fault(pte, lvl, wr, ep, ms[18], ms[19]);
                pa   = m_pa(pte, lvl, va);
            end
        end
        @(posedge clk); #1;
        exp_pa = flt ? 34'h3_FFFF_FFFF : pa;
        exp_fault = flt; exp_hit = idx >= 0; exp_miss = miss; exp_active = 1;
        address = va; is_write = wr; privilege_mode = pr; mstatus = ms; satp = sp;
        walk_pte = pte; walk_level = lvl; valid = 1;
        while (!ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            walk_ready = 0;
            tlb_flush = 0;
            if (walk_valid) begin
                walks++;
                if (fl && walks == 1) tlb_flush = 1;
                if (walks > dly) walk_ready = 1;
            end
        end
        check("ready_timeout", 34'(ready), 34'd1);
        walk_ready = 0; tlb_flush = 0; valid = 0;
        check("latency", 34'(cyc), 34'(miss ? walks + 2 : 1));
        check("walk_cycles", 34'(walks), 34'(miss ? dly + 1 : 0));
        last_pa = physical_address; last_fault = page_fault; last_hit = tlb_hit;
        last_lat = cyc; last_walks = walks;
        if (miss && fl) m_reset_entries();
        else if (miss && !flt) m_fill(va, sp[30:22], pte, lvl);
        @(posedge clk); #1;
        exp_active = 0; exp_miss = 0;
    endtask

    function automatic void m_reset_entries();
        for (int i = 0; i < N; i++) m_v[i] = 0;
    endfunction

    task automatic flush();
        @(posedge clk); #1; tlb_flush = 1;
        @(posedge clk); #1; tlb_flush = 0;
        m_reset_entries();
    endtask

    logic [31:0] pool_va [6] = '{32'h1000_0000, 32'h1000_1000, 32'h2040_0000, 32'h3000_5000, 32'h50C0_0000, 32'h6000_2000};
    bit          pool_mega [6] = '{0, 0, 1, 0, 1, 0};
    bit          pool_g [6] = '{0, 1, 0, 1, 0, 0};

    initial begin
        logic [31:0] va, pte, ms, sp;
        logic [7:0]  fb;
        logic [1:0]  pr, mpp;
        int          k;
        {address, is_write, privilege_mode, satp, mstatus, valid} = '0;
        {walk_ready, walk_pte, walk_level, tlb_flush} = '0;
        m_reset();
        #12;
        check("rst_ready", 34'(ready), 34'd0);
        check("rst_fault", 34'(page_fault), 34'd0);
        check("rst_hit", 34'(tlb_hit), 34'd0);
        check("rst_walk", 34'(walk_valid), 34'd0);
        check("rst_pa", physical_address, 34'd0);
        @(posedge clk); #1; resetn = 1;

        req(32'h8000_1234, 0, 2'd3, 0, S1, 0, 0, 0, 0);
        check("t1_pa", last_pa, 34'h0_8000_1234);
        check("t1_lat", 34'(last_lat), 34'd1);
        check("t1_walks", 34'(last_walks), 34'd0);
        req(32'h9000_0010, 1, 2'd1, 0, 32'h0040_0000, 0, 0, 0, 0);
        check("bare_pa", last_pa, 34'h0_9000_0010);

        req(32'h4000_0ABC, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 2, 0);
        check("t2_pa", last_pa, 34'h0_8000_0ABC);
        check("t2_lat", 34'(last_lat), 34'd5);
        check("t2_miss", 34'(last_hit), 34'd0);
        req(32'h4000_0ABC, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("t2_hit", 34'(last_hit), 34'd1);
        check("t2_hit_lat", 34'(last_lat), 34'd1);
        req(32'h4000_0ABC, 0, 2'd3, 32'h0002_0800, S1, 0, 0, 0, 0);
        check("mprv_hit", 34'(last_hit), 34'd1);
        check("mprv_pa", last_pa, 34'h0_8000_0ABC);

        req(32'h0040_0123, 0, 2'd0, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("t3_fault", 34'(last_fault), 34'd1);
        check("t3_pa", last_pa, 34'h3_FFFF_FFFF);
        req(32'h0040_0123, 0, 2'd0, 0, S1, 32'h2000_00CF, 0, 1, 0);
        check("t3_not_filled", 34'(last_hit), 34'd0);
        req(32'h0080_0000, 0, 2'd1, 0, S1, 32'h2000_04CF, 1, 0, 0);
        check("t3_misaligned", 34'(last_fault), 34'd1);

        flush();
        for (int i = 0; i < 5; i++) req(32'h0100_0000 + 32'(i) * 32'h1000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        req(32'h0100_3000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("t4_d_hit", 34'(last_hit), 34'd1);
        req(32'h0100_0000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("t4_a_evicted", 34'(last_hit), 34'd0);
        flush();
        req(32'h0100_1000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("t4_b_flushed", 34'(last_hit), 34'd0);

        req(32'h0D00_0123, 1, 2'd1, 0, S1, 32'h2000_004F, 0, 0, 0);
`ifdef SV32_AD_CHECK_EN
        check("t5_fault", 34'(last_fault), 34'd1);
`else
        check("t5_pa", last_pa, 34'h0_8000_0123);
        check("t5_fault", 34'(last_fault), 34'd0);
`endif

        flush();
        req(32'h0A00_0000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        req(32'h0B00_0000, 0, 2'd1, 0, S1, 32'h2000_00EF, 0, 0, 0);
        req(32'h0A00_0000, 0, 2'd1, 0, S2, 32'h2000_00CF, 0, 0, 0);
        check("t6_asid_miss", 34'(last_hit), 34'd0);
        req(32'h0B00_0000, 0, 2'd1, 0, S2, 32'h2000_00EF, 0, 0, 0);
        check("t6_global_hit", 34'(last_hit), 34'd1);

        req(32'h0C00_0040, 0, 2'd1, 32'h0008_0000, S1, 32'h2000_00C9, 0, 0, 0);
        check("mxr_ok", 34'(last_fault), 34'd0);
        req(32'h0C00_0040, 0, 2'd1, 0, S1, 32'h2000_00C9, 0, 0, 0);
        check("mxr_recheck_hit", 34'(last_hit), 34'd1);
        check("mxr_recheck_fault", 34'(last_fault), 34'd1);

        req(32'h0E00_0000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 1, 1);
        check("flush_walk_pa", last_pa, 34'h0_8000_0000);
        req(32'h0E00_0000, 0, 2'd1, 0, S1, 32'h2000_00CF, 0, 0, 0);
        check("flush_walk_not_filled", 34'(last_hit), 34'd0);

        @(posedge clk); #1;
        address = 32'h7000_1000; is_write = 0; privilege_mode = 2'd1; mstatus = 0; satp = S1;
        exp_miss = 1; valid = 1;
        for (int i = 0; i < 5 && !walk_valid; i++) begin @(posedge clk); #1; end
        check("drop_walk_started", 34'(walk_valid), 34'd1);
        valid = 0; walk_pte = 32'h2000_00CF; walk_level = 0; walk_ready = 1;
        @(posedge clk); #1; walk_ready = 0;
        for (int i = 0; i < 4; i++) begin
            check("drop_no_ready", 34'(ready), 34'd0);
            @(posedge clk); #1;
        end
        exp_miss = 0;
        flush();

        @(posedge clk); #1;
        address = 32'h7000_0000; exp_miss = 1; valid = 1;
        for (int i = 0; i < 5 && !walk_valid; i++) begin @(posedge clk); #1; end
        check("rst_walk_started", 34'(walk_valid), 34'd1);
        resetn = 0; #1;
        check("rst_drops_walk", 34'(walk_valid), 34'd0);
        check("rst_mid_pa", physical_address, 34'd0);
        valid = 0;
        @(posedge clk); #1; resetn = 1; walk_ready = 1;
        @(posedge clk); #1; walk_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("late_walk_ready_ignored", {32'd0, ready, walk_valid}, 34'd0);
            @(posedge clk); #1;
        end
        exp_miss = 0;
        m_reset();
        req(32'h0B00_0000, 0, 2'd1, 0, S1, 32'h2000_00EF, 0, 0, 0);
        check("rst_cleared_tlb", 34'(last_hit), 34'd0);

        flush();
        for (int it = 0; it < 400; it++) begin
            k  = $urandom_range(0, 5);
            va = pool_va[k] | (pool_mega[k] ? ($urandom & 32'h003F_FFFF) : ($urandom & 32'h0000_0FFF));
            fb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fb[0] = 1;
            if ($urandom_range(0, 3) != 0) fb[7:6] = 2'b11;
            if ($urandom_range(0, 2) != 0) fb[1] = 1;
            fb[5] = pool_g[k];
            pte = {22'($urandom), 2'b00, fb};
            if (pool_mega[k] && $urandom_range(0, 4) != 0) pte[19:10] = '0;
            k   = $urandom_range(0, 2);
            pr  = k == 2 ? 2'd3 : 2'(k);
            k   = $urandom_range(0, 2);
            mpp = k == 2 ? 2'd3 : 2'(k);
            ms  = {12'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 4'd0, mpp, 11'd0};
            sp  = {($urandom_range(0, 9) != 0), 9'($urandom_range(1, 2)), 22'd0};
            if ($urandom_range(0, 19) == 0) flush();
            req(va, 1'($urandom), pr, ms, sp, pte, pool_mega[k % 6 == 0 ? 0 : 0] | pool_mega_of(va),
                $urandom_range(0, 3), $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic bit pool_mega_of(logic [31:0] va);
        for (int i = 0; i < 6; i++) if (pool_mega[i] && va[31:22] == pool_va[i][31:22]) return 1;
        return 0;
    endfunction
endmodule
